// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the pipeline and the sequential divider.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, op, dividend, divisor,
      input  busy, done, result
   );

   modport slave (
      input  start, op, dividend, divisor,
      output busy, done, result
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             is_rem_q, is_rem_d;
   logic             neg_quo_q, neg_quo_d;
   logic             neg_rem_q, neg_rem_d;
   logic             div0_q, div0_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [WIDTH:0]   trial;
   logic             is_signed;
   logic             dvd_neg;
   logic             dvs_neg;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

   // Next-state and next-register values
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      dvd_d     = dvd_q;
      is_rem_d  = is_rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      result_d  = result_q;

      is_signed = ~bus.op[0];
      dvd_neg   = is_signed & bus.dividend[WIDTH-1];
      dvs_neg   = is_signed & bus.divisor[WIDTH-1];
      // Borrow out of the WIDTH+1-bit subtract lands in the top bit
      trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               is_rem_d  = bus.op[1];
               neg_quo_d = dvd_neg ^ dvs_neg;
               neg_rem_d = dvd_neg;
               div0_d    = (bus.divisor == '0);
               ovf_d     = is_signed & (bus.dividend == MIN_VAL) & (bus.divisor == '1);
               dvd_d     = bus.dividend;
               quo_d     = dvd_neg ? (WIDTH'(0) - bus.dividend) : bus.dividend;
               dvs_d     = dvs_neg ? (WIDTH'(0) - bus.divisor) : bus.divisor;
               rem_d     = '0;
               cnt_d     = CW'(WIDTH);
               busy_d    = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            if (div0_q) begin
               result_d = is_rem_q ? dvd_q : '1;
            end else if (ovf_q) begin
               result_d = is_rem_q ? '0 : MIN_VAL;
            end else if (is_rem_q) begin
               result_d = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
            end else begin
               result_d = neg_quo_q ? (WIDTH'(0) - quo_q) : quo_q;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         dvd_q     <= dvd_d;
         is_rem_q  <= is_rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
      end
   end
endmodule
